// File: rtl/jelly_data_split_id_pkg.sv
// Shared constants and helpers for the jelly_data_split_id slice.
//   BUF_DEPTH  : entries in each per-channel buffer
//   CNT_WIDTH  : width of a buffer occupancy register (holds 0..BUF_DEPTH)
//   id_legal() : true when an id addresses an existing channel
package jelly_data_split_id_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = 2;

    function automatic logic id_legal(input int unsigned id, input int unsigned num);
        return id < num;
    endfunction

endpackage

// File: rtl/jelly_data_split_id_buf.sv
// One output channel of the id splitter: a registered 2-entry FIFO.
// Optional feature macro: JELLY_DATA_SPLIT_ID_COUNT_EN adds the handshake counter.
// Ports:
//   reset_n, clk, cke       async active-low reset, clock, clock enable
//   push, push_data         write strobe (caller guarantees !full and cke) and payload
//   full                    occupancy == BUF_DEPTH (registered, no m_ready path)
//   m_data, m_valid,m_ready output stream; m_data is the head register
//   count                   completed m handshakes, wrapping (macro only)
module jelly_data_split_id_buf
    import jelly_data_split_id_pkg::*;
    #(
        parameter int DATA_WIDTH  = 32
`ifdef JELLY_DATA_SPLIT_ID_COUNT_EN
       ,parameter int COUNT_WIDTH = 16
`endif
    )
    (
        input  logic                  reset_n,
        input  logic                  clk,
        input  logic                  cke,
        input  logic                  push,
        input  logic [DATA_WIDTH-1:0] push_data,
        output logic                  full,
        output logic [DATA_WIDTH-1:0] m_data,
        output logic                  m_valid,
        input  logic                  m_ready
`ifdef JELLY_DATA_SPLIT_ID_COUNT_EN
       ,output logic [COUNT_WIDTH-1:0] count
`endif
    );

    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;

    assign m_valid = cke & (cnt != '0);
    assign pop     = m_valid & m_ready;
    assign full    = (cnt == CNT_WIDTH'(BUF_DEPTH));
    assign m_data  = head;

    // Head only moves when a word actually replaces it, so an emptied
    // buffer keeps presenting its last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else if (cke) begin
            case ({push, pop})
                2'b10: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) head <= push_data;
                    else           tail <= push_data;
                end
                2'b01: begin
                    cnt <= cnt - 1'b1;
                    if (full) head <= tail;
                end
                2'b11: begin
                    // occupancy unchanged; push lands behind whatever remains
                    if (full) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef JELLY_DATA_SPLIT_ID_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  count <= '0;
        else if (pop)  count <= count + 1'b1;
    end
`endif

endmodule

// File: rtl/jelly_data_split_id.sv
// Routes one {id,data} stream to NUM output channels, each with its own
// 2-entry buffer so a stalled channel only blocks while the input head targets it.
// Optional feature macro: JELLY_DATA_SPLIT_ID_COUNT_EN adds m_count.
// Ports:
//   reset_n, clk, cke          async active-low reset, clock, clock enable
//   s_id, s_data, s_valid      input word; ids >= NUM are accepted and dropped
//   s_ready                    depends only on registers and s_id
//   m_data, m_valid, m_ready   per-channel outputs, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   err_id                     one-cycle pulse after an illegal id is dropped
//   m_count                    per-channel handshake counters (macro only)
module jelly_data_split_id
    import jelly_data_split_id_pkg::*;
    #(
        parameter int NUM         = 16,
        parameter int ID_WIDTH    = 4,
        parameter int DATA_WIDTH  = 32,
        parameter int COUNT_WIDTH = 16
    )
    (
        input  logic                       reset_n,
        input  logic                       clk,
        input  logic                       cke,
        input  logic [ID_WIDTH-1:0]        s_id,
        input  logic [DATA_WIDTH-1:0]      s_data,
        input  logic                       s_valid,
        output logic                       s_ready,
        output logic [NUM*DATA_WIDTH-1:0]  m_data,
        output logic [NUM-1:0]             m_valid,
        input  logic [NUM-1:0]             m_ready,
        output logic                       err_id
`ifdef JELLY_DATA_SPLIT_ID_COUNT_EN
       ,output logic [NUM*COUNT_WIDTH-1:0] m_count
`endif
    );

    if (NUM < 1 || NUM > (1 << ID_WIDTH) || COUNT_WIDTH < 1) begin : g_bad_param
        $error("jelly_data_split_id: bad NUM/ID_WIDTH/COUNT_WIDTH");
    end

    logic [NUM-1:0]                 full;
    logic [NUM-1:0]                 push;
    logic [NUM-1:0][DATA_WIDTH-1:0] data_arr;
    logic                           id_ok;
    logic                           full_sel;
    logic                           accept;

    assign id_ok = id_legal(32'(s_id), NUM);

    // Selecting by compare instead of full[s_id] keeps illegal ids from
    // indexing past the array.
    always_comb begin
        full_sel = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (s_id == ID_WIDTH'(i)) full_sel = full[i];
        end
    end

    assign s_ready = cke & (~id_ok | ~full_sel);
    assign accept  = s_valid & s_ready;

`ifdef JELLY_DATA_SPLIT_ID_COUNT_EN
    logic [NUM-1:0][COUNT_WIDTH-1:0] count_arr;
    assign m_count = count_arr;
`endif

    for (genvar i = 0; i < NUM; i++) begin : g_ch
        assign push[i] = accept & id_ok & (s_id == ID_WIDTH'(i));

        jelly_data_split_id_buf
            #(
                .DATA_WIDTH  (DATA_WIDTH)
`ifdef JELLY_DATA_SPLIT_ID_COUNT_EN
               ,.COUNT_WIDTH (COUNT_WIDTH)
`endif
            )
            u_buf
            (
                .reset_n   (reset_n),
                .clk       (clk),
                .cke       (cke),
                .push      (push[i]),
                .push_data (s_data),
                .full      (full[i]),
                .m_data    (data_arr[i]),
                .m_valid   (m_valid[i]),
                .m_ready   (m_ready[i])
`ifdef JELLY_DATA_SPLIT_ID_COUNT_EN
               ,.count     (count_arr[i])
`endif
            );
    end

    assign m_data = data_arr;

    // Frozen with the rest of the state while cke is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  err_id <= 1'b0;
        else if (cke)  err_id <= accept & ~id_ok;
    end

endmodule
